// File: rtl/cnn_pkg.sv
// Shared definitions for the cellular neural network engine: config address map,
// FSM state encoding and the saturate/clamp arithmetic helpers.
package cnn_pkg;

  localparam int TAPS        = 9;
  localparam int ADDR_A_BASE = 0;
  localparam int ADDR_B_BASE = 9;
  localparam int ADDR_BIAS   = 18;
  localparam int ADDR_U_BASE = 19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SWEEP,
    ST_CHECK,
    ST_DONE
  } state_e;

  // Saturate a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Output nonlinearity: limit to [-ONE, +ONE] where ONE = 1 << frac.
  function automatic logic signed [63:0] clamp_one(input logic signed [63:0] v, input int frac);
    logic signed [63:0] one;
    one = 64'sd1 <<< frac;
    if (v > one) return one;
    if (v < -one) return -one;
    return v;
  endfunction

endpackage

// File: rtl/cnn_engine_seq_if.sv
// Config, control and readback bundle of the cellular neural network engine.
interface cnn_engine_seq_if #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int WIDTH    = 9,
  parameter int MAX_ITER = 16
);
  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(19 + N);
  localparam int RW = $clog2(N);
  localparam int IW = $clog2(MAX_ITER + 1);

  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [WIDTH-1:0] cfg_data;
  logic             start;
  logic             busy;
  logic             done;
  logic             converged;
  logic [IW-1:0]    iter_count;
  logic [RW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, rd_addr,
    input  busy, done, converged, iter_count, rd_data
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, rd_addr,
    output busy, done, converged, iter_count, rd_data
  );
endinterface

// File: rtl/cnn_cell_mac.sv
// Combinational single-cell update: 3x3 feedback (A*y) plus 3x3 control (B*u)
// plus bias, floor-shifted back to WIDTH, saturated, then clamped to +/-ONE.
module cnn_cell_mac
  import cnn_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int FRAC  = 4
) (
  input  logic signed [WIDTH-1:0] a_i    [TAPS],
  input  logic signed [WIDTH-1:0] b_i    [TAPS],
  input  logic signed [WIDTH-1:0] y_i    [TAPS],
  input  logic signed [WIDTH-1:0] u_i    [TAPS],
  input  logic signed [WIDTH-1:0] bias_i,
  output logic signed [WIDTH-1:0] y_o
);
  localparam int PW    = 2 * WIDTH;
  localparam int ACC_W = 2 * WIDTH + 5;

  logic signed [PW-1:0]    pa;
  logic signed [PW-1:0]    pb;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;
  logic signed [63:0]      wide;

  always_comb begin
    pa  = '0;
    pb  = '0;
    acc = ACC_W'(bias_i) <<< FRAC;
    for (int k = 0; k < TAPS; k++) begin
      pa  = PW'(a_i[k]) * PW'(y_i[k]);
      pb  = PW'(b_i[k]) * PW'(u_i[k]);
      acc = acc + ACC_W'(pa) + ACC_W'(pb);
    end
    // Arithmetic shift gives floor rounding toward -inf.
    shifted = acc >>> FRAC;
    wide    = clamp_one(sat_w(64'(shifted), WIDTH), FRAC);
    y_o     = wide[WIDTH-1:0];
  end

endmodule

// File: rtl/cnn_engine_seq.sv
// Sequential discrete-time CNN engine: one cell per cycle, Jacobi sweeps over a
// double-buffered Y array until the outputs stop changing or MAX_ITER is hit.
module cnn_engine_seq
  import cnn_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int WIDTH    = 9,
  parameter int FRAC     = 4,
  parameter int MAX_ITER = 16
) (
  input logic               clk,
  input logic               rst_n,
  cnn_engine_seq_if.slave   bus
);
  localparam int N   = ROWS * COLS;
  localparam int IW  = $clog2(MAX_ITER + 1);
  localparam int RBW = $clog2(ROWS + 1);
  localparam int CBW = $clog2(COLS + 1);

  state_e                  state_q;
  logic                    busy_q, done_q, conv_q, sel_q, changed_q;
  logic [IW-1:0]           iter_q;
  logic [RBW-1:0]          row_q;
  logic [CBW-1:0]          col_q;
  logic signed [WIDTH-1:0] a_q    [TAPS];
  logic signed [WIDTH-1:0] b_q    [TAPS];
  logic signed [WIDTH-1:0] bias_q;
  logic signed [WIDTH-1:0] u_q    [N];
  logic signed [WIDTH-1:0] ybuf_q [2][N];
  logic signed [WIDTH-1:0] rd_q;

  logic signed [WIDTH-1:0] y_nb [TAPS];
  logic signed [WIDTH-1:0] u_nb [TAPS];
  logic signed [WIDTH-1:0] y_new_d;
  logic signed [WIDTH-1:0] y_cur;
  int                      cell_idx;

  // Gather the 3x3 neighbourhood of the current cell from the Y_old buffer, zero-padded.
  always_comb begin
    int rr;
    int cc;
    cell_idx = int'(row_q) * COLS + int'(col_q);
    y_cur    = ybuf_q[sel_q][cell_idx];
    for (int k = 0; k < TAPS; k++) begin
      y_nb[k] = '0;
      u_nb[k] = '0;
    end
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        rr = int'(row_q) + dr - 1;
        cc = int'(col_q) + dc - 1;
        if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
          y_nb[dr*3+dc] = ybuf_q[sel_q][rr*COLS+cc];
          u_nb[dr*3+dc] = u_q[rr*COLS+cc];
        end
      end
    end
  end

  cnn_cell_mac #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_mac (
    .a_i    (a_q),
    .b_i    (b_q),
    .y_i    (y_nb),
    .u_i    (u_nb),
    .bias_i (bias_q),
    .y_o    (y_new_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      conv_q    <= 1'b0;
      sel_q     <= 1'b0;
      changed_q <= 1'b0;
      iter_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      for (int i = 0; i < N; i++) begin
        ybuf_q[0][i] <= '0;
        ybuf_q[1][i] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_INIT;
            busy_q  <= 1'b1;
          end
        end
        ST_INIT: begin
          for (int i = 0; i < N; i++) begin
            ybuf_q[0][i] <= '0;
            ybuf_q[1][i] <= '0;
          end
          iter_q    <= '0;
          conv_q    <= 1'b0;
          sel_q     <= 1'b0;
          changed_q <= 1'b0;
          row_q     <= '0;
          col_q     <= '0;
          state_q   <= ST_SWEEP;
        end
        ST_SWEEP: begin
          ybuf_q[~sel_q][cell_idx] <= y_new_d;
          if (y_new_d != y_cur) changed_q <= 1'b1;
          if (col_q == CBW'(COLS - 1)) begin
            col_q <= '0;
            if (row_q == RBW'(ROWS - 1)) state_q <= ST_CHECK;
            else                         row_q   <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        ST_CHECK: begin
          // Y_new becomes the visible buffer for readback and the next sweep.
          sel_q     <= ~sel_q;
          iter_q    <= iter_q + 1'b1;
          changed_q <= 1'b0;
          row_q     <= '0;
          col_q     <= '0;
          if (!changed_q) begin
            conv_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (iter_q + 1'b1 == IW'(MAX_ITER)) begin
            conv_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_SWEEP;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Configuration writes land only while idle; addresses past the U range drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_q <= '0;
      for (int k = 0; k < TAPS; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int i = 0; i < N; i++) u_q[i] <= '0;
    end else if (bus.cfg_we && state_q == ST_IDLE) begin
      if (int'(bus.cfg_addr) < ADDR_B_BASE)
        a_q[int'(bus.cfg_addr) - ADDR_A_BASE] <= $signed(bus.cfg_data);
      else if (int'(bus.cfg_addr) < ADDR_BIAS)
        b_q[int'(bus.cfg_addr) - ADDR_B_BASE] <= $signed(bus.cfg_data);
      else if (int'(bus.cfg_addr) == ADDR_BIAS)
        bias_q <= $signed(bus.cfg_data);
      else if (int'(bus.cfg_addr) < ADDR_U_BASE + N)
        u_q[int'(bus.cfg_addr) - ADDR_U_BASE] <= $signed(bus.cfg_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      rd_q <= '0;
    else if (int'(bus.rd_addr) < N)  rd_q <= ybuf_q[sel_q][bus.rd_addr];
    else                             rd_q <= '0;
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.converged  = conv_q;
  assign bus.iter_count = iter_q;
  assign bus.rd_data    = rd_q;

endmodule

// File: tb/tb_cnn_engine_seq.sv
// Directed and randomized bench for cnn_engine_seq against a grid-level CNN model.
module tb_cnn_engine_seq;
  localparam int ROWS = 4, COLS = 4, WIDTH = 9, FRAC = 4, MAX_ITER = 16;
  localparam int N = ROWS * COLS;
  localparam int ONE = 1 << FRAC;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cnn_engine_seq_if #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH), .MAX_ITER(MAX_ITER)) bus ();

  cnn_engine_seq #(
    .ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH), .FRAC(FRAC), .MAX_ITER(MAX_ITER)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int passed = 0;
  int mA[9], mB[9], mU[N], mI;
  int exp_y[N];
  int exp_iter, exp_conv;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 9; k++) begin mA[k] = 0; mB[k] = 0; end
    for (int i = 0; i < N; i++) mU[i] = 0;
    mI = 0;
  endtask

  // Jacobi iteration over the grid with zero padding, then saturate and clamp.
  task automatic model_run();
    int yo[N], yn[N];
    int acc, x, rr, cc;
    bit changed;
    for (int i = 0; i < N; i++) yo[i] = 0;
    exp_conv = 0;
    exp_iter = 0;
    for (int it = 1; it <= MAX_ITER; it++) begin
      changed = 0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          acc = mI * ONE;
          for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
              rr = r + dr;
              cc = c + dc;
              if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
                acc += mA[(dr+1)*3 + dc+1] * yo[rr*COLS+cc] + mB[(dr+1)*3 + dc+1] * mU[rr*COLS+cc];
            end
          end
          x = acc >>> FRAC;
          if (x > 255) x = 255;
          if (x < -256) x = -256;
          if (x > ONE) x = ONE;
          if (x < -ONE) x = -ONE;
          yn[r*COLS+c] = x;
          if (x != yo[r*COLS+c]) changed = 1;
        end
      end
      for (int i = 0; i < N; i++) yo[i] = yn[i];
      exp_iter = it;
      if (!changed) begin
        exp_conv = 1;
        break;
      end
    end
    for (int i = 0; i < N; i++) exp_y[i] = yo[i];
  endtask

  task automatic cfg_write(input int addr, input int val);
    bus.cfg_addr = addr[5:0];
    bus.cfg_data = val[8:0];
    bus.cfg_we   = 1'b1;
    @(posedge clk); #1;
    bus.cfg_we   = 1'b0;
  endtask

  task automatic push_config();
    for (int k = 0; k < 9; k++) cfg_write(k, mA[k]);
    for (int k = 0; k < 9; k++) cfg_write(9 + k, mB[k]);
    cfg_write(18, mI);
    for (int i = 0; i < N; i++) cfg_write(19 + i, mU[i]);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.cfg_we = 1'b0; bus.start = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.rd_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic start_run(input string tag);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_busy_init"}, int'(bus.busy), 1);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 0;
    for (int c = 0; c < MAX_ITER * (N + 1) + 20; c++) begin
      if (bus.done) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    check({tag, "_done_seen"}, int'(seen), 1);
    check({tag, "_busy_in_done"}, int'(bus.busy), 1);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, int'(bus.done), 0);
    check({tag, "_busy_after"}, int'(bus.busy), 0);
    check({tag, "_converged"}, int'(bus.converged), exp_conv);
    check({tag, "_iter"}, int'(bus.iter_count), exp_iter);
  endtask

  task automatic check_y(input string tag);
    for (int k = 0; k < N; k++) begin
      bus.rd_addr = k[3:0];
      @(posedge clk); #1;
      check($sformatf("%s_y%0d", tag, k), int'($signed(bus.rd_data)), exp_y[k]);
    end
  endtask

  initial begin
    int v;
    apply_reset();
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_conv", int'(bus.converged), 0);
    check("rst_iter", int'(bus.iter_count), 0);
    for (int i = 0; i < N; i++) exp_y[i] = 0;
    check_y("rst");

    // Identity: centre B only, Y settles to U.
    apply_reset(); model_clear();
    mB[4] = 16; mU[5] = 16; mU[6] = 16; mU[9] = 16; mU[10] = 16;
    push_config(); model_run();
    check("ident_model_iter", exp_iter, 2);
    start_run("ident"); wait_done("ident");
    for (int i = 0; i < N; i++) exp_y[i] = mU[i];
    check_y("ident");

    // Padding: missing neighbours pull edges and corners negative.
    apply_reset(); model_clear();
    for (int k = 0; k < 9; k++) mB[k] = 16;
    for (int i = 0; i < N; i++) mU[i] = 16;
    mI = -128;
    push_config(); model_run();
    start_run("pad"); wait_done("pad");
    for (int i = 0; i < N; i++) exp_y[i] = (i == 5 || i == 6 || i == 9 || i == 10) ? 16 : -16;
    check_y("pad");

    // Saturation of a huge product.
    apply_reset(); model_clear();
    mB[4] = 255;
    for (int i = 0; i < N; i++) mU[i] = 255;
    push_config(); model_run();
    start_run("sat"); wait_done("sat");
    for (int i = 0; i < N; i++) exp_y[i] = 16;
    check_y("sat");

    // Oscillation with mid-run start / cfg_we that must be ignored.
    apply_reset(); model_clear();
    mA[4] = -32; mI = 16;
    push_config(); model_run();
    start_run("osc");
    repeat (20) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.cfg_we = 1'b1; bus.cfg_addr = 6'd4; bus.cfg_data = 9'd0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.cfg_we = 1'b0;
    wait_done("osc");
    check("osc_iter_lit", int'(bus.iter_count), 16);
    check("osc_conv_lit", int'(bus.converged), 0);
    check_y("osc");
    start_run("osc2"); wait_done("osc2");
    check_y("osc2");

    // Reset during a sweep, then a run with no configuration.
    start_run("midrst");
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_iter", int'(bus.iter_count), 0);
    rst_n = 1'b1;
    model_clear(); model_run();
    start_run("zero"); wait_done("zero");
    check_y("zero");

    // Random templates, bias and inputs, with a stray out-of-map write.
    for (int t = 0; t < 4; t++) begin
      apply_reset(); model_clear();
      for (int k = 0; k < 9; k++) begin
        mA[k] = int'($urandom_range(40)) - 20;
        mB[k] = int'($urandom_range(40)) - 20;
      end
      for (int i = 0; i < N; i++) mU[i] = int'($urandom_range(32)) - 16;
      mI = int'($urandom_range(32)) - 16;
      push_config();
      v = 35 + int'($urandom_range(28));
      cfg_write(v, int'($urandom_range(511)));
      model_run();
      start_run($sformatf("rnd%0d", t)); wait_done($sformatf("rnd%0d", t));
      check_y($sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cnn_engine_seq.md
CNN_ENGINE_SEQ -- requirements
Module: cnn_engine_seq

Interface
REQ-001 SHALL have parameter ROWS, default 4, meaning cell-array rows.
REQ-002 SHALL have parameter COLS, default 4, meaning cell-array columns; N = ROWS*COLS.
REQ-003 SHALL have parameter WIDTH, default 9, meaning signed two's-complement data width.
REQ-004 SHALL have parameter FRAC, default 4, meaning fractional bits; ONE = 1<<FRAC.
REQ-005 SHALL have parameter MAX_ITER, default 16, meaning sweep limit per run.
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge clock.
REQ-007 SHALL have rst_n input 1, asynchronous active-low reset.
REQ-008 SHALL have cfg_we input 1, config write strobe.
REQ-009 SHALL have cfg_addr input clog2(19+N): 0-8 A template, 9-17 B template, 18 bias I, 19..18+N cell input U (row-major).
REQ-010 SHALL have cfg_data input WIDTH, config value.
REQ-011 SHALL have start input 1, run request.
REQ-012 SHALL have busy output 1, run in progress.
REQ-013 SHALL have done output 1, one-cycle end-of-run pulse.
REQ-014 SHALL have converged output 1, last run ended with no output change.
REQ-015 SHALL have iter_count output clog2(MAX_ITER+1), sweeps done in last run.
REQ-016 SHALL have rd_addr input clog2(N), output cell select.
REQ-017 SHALL have rd_data output WIDTH, registered Y of rd_addr, one-cycle latency.

Function
REQ-018 SHALL implement a discrete-time cellular neural network: x_ij = sum(A*y_kl) + sum(B*u_kl) + I over the 3x3 neighbourhood; y = clamp(x, -ONE, +ONE).
REQ-019 SHALL treat out-of-array neighbours as y=0, u=0 (zero padding).
REQ-020 SHALL form each product at 2*WIDTH bits, accumulate at 2*WIDTH+5 bits, add I<<FRAC, arithmetic-shift right FRAC (floor), then saturate to WIDTH signed range.
REQ-021 SHALL process one cell per cycle, row-major; one sweep = N cycles.
REQ-022 SHALL update Jacobi-style: sweep reads Y_old buffer, writes Y_new buffer; buffers swap at sweep end.
REQ-023 SHALL use FSM IDLE -> INIT (1 cycle: Y buffers cleared to 0, iter_count=0) -> SWEEP (N cycles) -> CHECK (1 cycle) -> SWEEP or DONE -> IDLE.
REQ-024 SHALL in CHECK increment iter_count; go DONE if no cell changed (converged=1) or iter_count reached MAX_ITER (converged=0); else SWEEP.
REQ-025 SHALL assert done for exactly the DONE cycle; busy high from INIT through DONE inclusive.
REQ-026 SHALL accept start only in IDLE; start while busy ignored.
REQ-027 SHALL ignore cfg_we while busy; in IDLE, cfg_addr beyond 18+N ignored.
REQ-028 SHALL hold converged, iter_count and Y after DONE until next start.
REQ-029 SHALL serve rd_data from the current Y buffer at any time.

Reset
REQ-030 SHALL on rst_n low return to IDLE immediately, mid-run included; busy, done, converged, iter_count, rd_data, templates, I, U and Y all 0.

Structure
REQ-031 SHALL place the config address map constants, FSM state typedef and saturate/clamp helper functions in shared package cnn_pkg.
REQ-032 SHALL instantiate one sub-module cnn_cell_mac: 18 multiplies plus bias, shift and saturate, combinational, one cell per cycle.

Verification (defaults, ONE=16)
REQ-033 Reset: rst_n low -> all outputs 0; rd_data=0 for every rd_addr.
REQ-034 Identity: B5=16, rest 0, I=0, U=16 at cells 5,6,9,10 else 0 -> converged=1, iter_count=2, Y equals U.
REQ-035 Padding: all B=16, A=0, I=-128, all U=16 -> inner cells 5,6,9,10 Y=16; edge and corner cells Y=-16; converged=1, iter_count=2.
REQ-036 Saturation: B5=255, U all 255, I=0 -> x saturates to 255, every Y=16.
REQ-037 Oscillation: A5=-32, B=0, I=16 -> Y alternates 16/-16; done with iter_count=16, converged=0.
REQ-038 Control: start and cfg_we mid-run ignored; rst_n low mid-sweep -> busy=0 next edge, templates zero, subsequent run with no config gives all Y=0.
